// File: rtl/game_pkg.sv
// Shared game types: main game FSM states plus the countdown timer types.
// Also holds the timer width, saturation limit and double-dabble helper.
package game_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    PLAY      = 3'd1,
    PAUSE     = 3'd2,
    WIN       = 3'd3,
    LOST      = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_HOLD    = 2'd2,
    T_EXPIRED = 2'd3
  } timer_state_t;

  localparam int TIMER_W = 10;
  localparam int BCD_W   = 4;
  localparam int BCD_N   = 3;

  localparam logic [TIMER_W-1:0] TIMER_MAX = 10'd999;

  // Clamp a start value to what three decimal digits can show.
  function automatic logic [TIMER_W-1:0] sat_load(
    input logic [TIMER_W-1:0] v
  );
    return (v > TIMER_MAX) ? TIMER_MAX : v;
  endfunction

  // Double-dabble digit correction applied before each shift.
  function automatic logic [BCD_W-1:0] dd_adj(
    input logic [BCD_W-1:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/game_timer_bin2bcd.sv
// Sequential double-dabble: 10-bit binary to three BCD digits.
// A start restarts any conversion in flight; done pulses one cycle.
module bin2bcd
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [TIMER_W-1:0] bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   hundreds_o,
  output logic [BCD_W-1:0]   tens_o,
  output logic [BCD_W-1:0]   ones_o
);

  localparam int SH_W = BCD_N * BCD_W + TIMER_W;

  logic [SH_W-1:0] sh_q, sh_d;
  logic [SH_W-1:0] adj;
  logic [3:0]      cnt_q, cnt_d;
  logic            done_q, done_d;

  // Correct each digit, then the caller shifts the whole register left.
  always_comb begin
    adj = {
      dd_adj(sh_q[21:18]),
      dd_adj(sh_q[17:14]),
      dd_adj(sh_q[13:10]),
      sh_q[9:0]
    };
  end

  // Load on start, otherwise shift once per cycle until all bits consumed.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start_i) begin
      sh_d  = {{(BCD_N*BCD_W){1'b0}}, bin_i};
      cnt_d = 4'(TIMER_W);
    end else if (cnt_q != 4'd0) begin
      sh_d   = {adj[SH_W-2:0], 1'b0};
      cnt_d  = cnt_q - 4'd1;
      done_d = (cnt_q == 4'd1);
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign hundreds_o = sh_q[21:18];
  assign tens_o     = sh_q[17:14];
  assign ones_o     = sh_q[13:10];

endmodule

// File: rtl/game_timer.sv
// Level countdown timer driven by the main game FSM state.
// BCD readout is built only when GAME_TIMER_BCD_EN is defined.
module game_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  state_t             state_in,
  input  logic [TIMER_W-1:0] timer_seconds,
  output logic [TIMER_W-1:0] seconds_left,
  output logic               tick_1hz,
  output logic               time_up,
  output logic [BCD_W-1:0]   bcd_hundreds,
  output logic [BCD_W-1:0]   bcd_tens,
  output logic [BCD_W-1:0]   bcd_ones
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  timer_state_t       state_q, state_d;
  state_t             prev_q;
  logic [TIMER_W-1:0] sec_q, sec_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               up_q, up_d;
  logic               tick_q, tick_d;

  // Next-state: load on MENU->PLAY, count PLAY cycles, freeze otherwise.
  // A non-PLAY state in the terminal cycle simply parks in T_HOLD.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    up_d    = up_q;
    tick_d  = 1'b0;
    unique case (state_q)
      T_IDLE: begin
        if (state_in == PLAY && prev_q == MENU) begin
          sec_d = sat_load(timer_seconds);
          pre_d = '0;
          if (timer_seconds == '0) begin
            state_d = T_EXPIRED;
            up_d    = 1'b1;
          end else begin
            state_d = T_RUN;
          end
        end
      end
      T_RUN, T_HOLD: begin
        if (state_in == PLAY) begin
          state_d = T_RUN;
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (sec_q != '0) begin
              sec_d  = sec_q - 1'b1;
              tick_d = 1'b1;
              if (sec_q == TIMER_W'(1)) begin
                state_d = T_EXPIRED;
                up_d    = 1'b1;
              end
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end else if (state_in != MENU) begin
          state_d = T_HOLD;
        end
      end
      T_EXPIRED: begin
        sec_d = '0;
        up_d  = 1'b1;
      end
      default: state_d = T_IDLE;
    endcase
    if (state_in == MENU) begin
      state_d = T_IDLE;
      sec_d   = '0;
      pre_d   = '0;
      up_d    = 1'b0;
      tick_d  = 1'b0;
    end
  end

  // Timer state registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_IDLE;
      prev_q  <= MENU;
      sec_q   <= '0;
      pre_q   <= '0;
      up_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= state_in;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      up_q    <= up_d;
      tick_q  <= tick_d;
    end
  end

  assign seconds_left = sec_q;
  assign tick_1hz     = tick_q;
  assign time_up      = up_q;

`ifdef GAME_TIMER_BCD_EN
  logic             cv_done;
  logic [BCD_W-1:0] cv_h, cv_t, cv_o;
  logic [BCD_W-1:0] h_q, t_q, o_q;

  bin2bcd u_bcd (
    .clk        (clk),
    .rst        (rst),
    .start_i    (sec_d != sec_q),
    .bin_i      (sec_d),
    .done_o     (cv_done),
    .hundreds_o (cv_h),
    .tens_o     (cv_t),
    .ones_o     (cv_o)
  );

  // Display digits change only when a full conversion lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      t_q <= '0;
      o_q <= '0;
    end else if (cv_done) begin
      h_q <= cv_h;
      t_q <= cv_t;
      o_q <= cv_o;
    end
  end

  assign bcd_hundreds = h_q;
  assign bcd_tens     = t_q;
  assign bcd_ones     = o_q;
`else
  assign bcd_hundreds = '0;
  assign bcd_tens     = '0;
  assign bcd_ones     = '0;
`endif

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLK_HZ, default 65_000_000, clk cycles per timer second.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 state_in  input  state_t  main game FSM state (MENU, PLAY, PAUSE, WIN, LOST, GAME_OVER).
REQ-005 timer_seconds  input  10  countdown start value for the selected level, valid while state_in==PLAY.
REQ-006 seconds_left  output  10  remaining seconds.
REQ-007 tick_1hz  output  1  one-cycle pulse on each decrement.
REQ-008 time_up  output  1  level, countdown expired; feeds the game-lost condition.
REQ-009 bcd_hundreds, bcd_tens, bcd_ones  output  4 each  BCD form of seconds_left.

Function
REQ-010 Internal FSM states SHALL be T_IDLE, T_RUN, T_HOLD, T_EXPIRED; registered prev_state SHALL hold last-cycle state_in.
REQ-011 T_IDLE: on state_in==PLAY with prev_state==MENU, load seconds_left<=timer_seconds, prescaler<=0, go T_RUN; if timer_seconds==0, go T_EXPIRED instead.
REQ-012 T_RUN: prescaler increments each cycle; at CLK_HZ-1 it wraps to 0, seconds_left decrements, tick_1hz pulses next cycle.
REQ-013 Decrement from 1 to 0 SHALL move to T_EXPIRED and assert time_up in the same cycle seconds_left reads 0.
REQ-014 T_RUN: state_in!=PLAY and !=MENU SHALL go T_HOLD with prescaler and seconds_left frozen.
REQ-015 Pause/terminal-count collision: a non-PLAY state_in in the terminal cycle takes priority; no decrement, no tick.
REQ-016 T_HOLD: state_in==PLAY returns to T_RUN resuming from frozen prescaler; never reloads from timer_seconds.
REQ-017 T_EXPIRED: seconds_left held 0, time_up held 1, no ticks.
REQ-018 From any state, state_in==MENU SHALL go T_IDLE next cycle, clearing seconds_left, prescaler, time_up.
REQ-019 seconds_left SHALL never underflow below 0.
REQ-020 timer_seconds values >999 SHALL saturate to 999 on load.

Reset
REQ-021 rst SHALL force T_IDLE, prev_state=MENU, seconds_left=0, prescaler=0, tick_1hz=0, time_up=0, BCD outputs=0.
REQ-022 rst mid-countdown SHALL take effect next edge, overriding all other transitions.

Configuration
REQ-023 Macro GAME_TIMER_BCD_EN defined: BCD outputs SHALL track seconds_left, updated within 12 cycles of any change.
REQ-024 Macro GAME_TIMER_BCD_EN undefined: converter not instantiated, BCD outputs tied to 0; all other behaviour identical.

Structure
REQ-025 game_pkg SHALL gain timer_state_t (four states above) and TIMER_W=10; state_t reused unchanged.
REQ-026 One sub-module bin2bcd: sequential double-dabble, 10-bit in, 3 BCD digits out, start/done handshake, restarted on each seconds_left change, outputs latched on done.

Verification (CLK_HZ=10)
REQ-027 MENU->PLAY with timer_seconds=3 -> seconds_left 3, ticks every 10 cycles to 0, time_up=1 on reaching 0, no further ticks.
REQ-028 PLAY 5 s, PAUSE after 4 prescaler cycles for 50 cycles, back to PLAY -> seconds_left frozen during PAUSE, next decrement 6 cycles after resume, no reload.
REQ-029 PAUSE asserted exactly at prescaler=9 -> no decrement, tick_1hz stays 0 that cycle.
REQ-030 timer_seconds=0 on entry to PLAY -> time_up=1 within 2 cycles, seconds_left=0, no ticks.
REQ-031 state_in MENU mid-countdown (seconds_left=7) -> seconds_left=0, time_up=0 next cycle; new PLAY with timer_seconds=4 loads 4.
REQ-032 With GAME_TIMER_BCD_EN, seconds_left=123 -> BCD outputs 1,2,3 within 12 cycles; without macro, all 0.
